// File: rtl/id_ctrl_stage.sv
// Instruction-decode stage: IF/ID register, opcode decode, load-use stall and EX flush into ID/EX.
// Optional feature macro ILLEGAL_TRAP_EN: unknown opcodes reach ID/EX as a valid slot flagged by illegal_o.
module id_ctrl_stage #(
    parameter int                 INSN_W   = 32,
    parameter logic [INSN_W-1:0]  NOP_INSN = 32'h00000013
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_valid_i,
    input  logic [INSN_W-1:0] if_instr_i,
    output logic              if_ready_o,
    input  logic              flush_i,
    output logic              ex_valid_o,
    output logic [1:0]        ALUOp_o,
    output logic [3:0]        funct_o,
    output logic              RegWrite_o,
    output logic              MemRead_o,
    output logic              MemWrite_o,
    output logic              MemtoReg_o,
    output logic              ALUSrc_o,
    output logic              Branch_o,
    output logic [4:0]        rs1_o,
    output logic [4:0]        rs2_o,
    output logic [4:0]        rd_o,
`ifdef ILLEGAL_TRAP_EN
    output logic              illegal_o,
`endif
    output logic              hazard_o
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    logic [INSN_W-1:0] r_ifid_instr;
    logic              r_ifid_valid;

    logic              r_ex_valid;
    logic [1:0]        r_aluop;
    logic [3:0]        r_funct;
    logic              r_reg_write, r_mem_read, r_mem_write, r_mem_to_reg, r_alu_src, r_branch;
    logic [4:0]        r_rs1, r_rs2, r_rd;

    logic [6:0] w_opcode;
    logic [2:0] w_f3;
    logic       w_b30;
    logic [4:0] w_rs1, w_rs2, w_rd;
    logic       w_unused;

    assign w_opcode = r_ifid_instr[6:0];
    assign w_rd     = r_ifid_instr[11:7];
    assign w_f3     = r_ifid_instr[14:12];
    assign w_rs1    = r_ifid_instr[19:15];
    assign w_rs2    = r_ifid_instr[24:20];
    assign w_b30    = r_ifid_instr[30];
    assign w_unused = ^{r_ifid_instr[INSN_W-1:31], r_ifid_instr[29:25]};

    logic       w_known, w_use_rs1, w_use_rs2;
    logic [1:0] w_aluop;
    logic [3:0] w_funct;
    logic       w_reg_write, w_mem_read, w_mem_write, w_mem_to_reg, w_alu_src, w_branch;

    always_comb begin
        w_known      = 1'b0;
        w_use_rs1    = 1'b0;
        w_use_rs2    = 1'b0;
        w_aluop      = 2'b00;
        w_funct      = 4'b0000;
        w_reg_write  = 1'b0;
        w_mem_read   = 1'b0;
        w_mem_write  = 1'b0;
        w_mem_to_reg = 1'b0;
        w_alu_src    = 1'b0;
        w_branch     = 1'b0;
        case (w_opcode)
            OP_R: begin
                w_known     = 1'b1;
                w_use_rs1   = 1'b1;
                w_use_rs2   = 1'b1;
                w_aluop     = 2'b10;
                w_funct     = {w_b30, w_f3};
                w_reg_write = 1'b1;
            end
            OP_I: begin
                // Only SRAI carries instr[30] into funct; other I-type immediates would alias SUB/SRA.
                w_known     = 1'b1;
                w_use_rs1   = 1'b1;
                w_aluop     = 2'b11;
                w_funct     = (w_f3 == 3'b101 && w_b30) ? 4'b1101 : {1'b0, w_f3};
                w_reg_write = 1'b1;
                w_alu_src   = 1'b1;
            end
            OP_LOAD: begin
                w_known      = 1'b1;
                w_use_rs1    = 1'b1;
                w_reg_write  = 1'b1;
                w_alu_src    = 1'b1;
                w_mem_read   = 1'b1;
                w_mem_to_reg = 1'b1;
            end
            OP_STORE: begin
                w_known     = 1'b1;
                w_use_rs1   = 1'b1;
                w_use_rs2   = 1'b1;
                w_alu_src   = 1'b1;
                w_mem_write = 1'b1;
            end
            OP_BRANCH: begin
                w_known   = 1'b1;
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
                w_aluop   = 2'b01;
                w_branch  = 1'b1;
            end
            default: ;
        endcase
    end

    logic w_hazard, w_load_slot, w_dec_en, w_slot_valid;

    assign w_hazard = r_ex_valid & r_mem_read & (r_rd != 5'd0) & r_ifid_valid &
                      ((w_use_rs1 & (w_rs1 == r_rd)) | (w_use_rs2 & (w_rs2 == r_rd)));

    // Handshake: IF transfers on a cycle where if_valid_i & if_ready_o; ready drops only for a
    // load-use stall, and a flush forces ready high while the offered instruction is dropped.
    assign hazard_o   = w_hazard & ~flush_i;
    assign if_ready_o = ~hazard_o;

    assign w_load_slot = r_ifid_valid & ~w_hazard & ~flush_i;
    assign w_dec_en    = w_load_slot & w_known;
`ifdef ILLEGAL_TRAP_EN
    assign w_slot_valid = w_load_slot;
`else
    assign w_slot_valid = w_dec_en;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            r_ifid_instr <= NOP_INSN;
            r_ifid_valid <= 1'b0;
        end else if (!w_hazard) begin
            r_ifid_valid <= if_valid_i;
            if (if_valid_i) begin
                r_ifid_instr <= if_instr_i;
            end
        end
    end

    // Bubbles, invalid slots and unknown opcodes all register zero control and indices.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ex_valid   <= 1'b0;
            r_aluop      <= 2'b00;
            r_funct      <= 4'b0000;
            r_reg_write  <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_alu_src    <= 1'b0;
            r_branch     <= 1'b0;
            r_rs1        <= 5'd0;
            r_rs2        <= 5'd0;
            r_rd         <= 5'd0;
        end else begin
            r_ex_valid   <= w_slot_valid;
            r_aluop      <= w_dec_en ? w_aluop : 2'b00;
            r_funct      <= w_dec_en ? w_funct : 4'b0000;
            r_reg_write  <= w_dec_en & w_reg_write;
            r_mem_read   <= w_dec_en & w_mem_read;
            r_mem_write  <= w_dec_en & w_mem_write;
            r_mem_to_reg <= w_dec_en & w_mem_to_reg;
            r_alu_src    <= w_dec_en & w_alu_src;
            r_branch     <= w_dec_en & w_branch;
            r_rs1        <= w_dec_en ? w_rs1 : 5'd0;
            r_rs2        <= w_dec_en ? w_rs2 : 5'd0;
            r_rd         <= w_dec_en ? w_rd  : 5'd0;
        end
    end

`ifdef ILLEGAL_TRAP_EN
    logic r_illegal;
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_illegal <= 1'b0;
        end else begin
            r_illegal <= w_load_slot & ~w_known;
        end
    end
    assign illegal_o = r_illegal;
`endif

    assign ex_valid_o = r_ex_valid;
    assign ALUOp_o    = r_aluop;
    assign funct_o    = r_funct;
    assign RegWrite_o = r_reg_write;
    assign MemRead_o  = r_mem_read;
    assign MemWrite_o = r_mem_write;
    assign MemtoReg_o = r_mem_to_reg;
    assign ALUSrc_o   = r_alu_src;
    assign Branch_o   = r_branch;
    assign rs1_o      = r_rs1;
    assign rs2_o      = r_rs2;
    assign rd_o       = r_rd;

endmodule

// File: tb/tb_id_ctrl_stage.sv
// Bench for id_ctrl_stage: directed decode/stall/flush/reset steps, then random traffic against a
// cycle-level reference model built from the decode table and load-use rule.
module tb_id_ctrl_stage;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        if_valid_i = 1'b0;
    logic [31:0] if_instr_i = 32'h0;
    logic        flush_i = 1'b0;
    logic        if_ready_o, ex_valid_o, hazard_o;
    logic [1:0]  ALUOp_o;
    logic [3:0]  funct_o;
    logic        RegWrite_o, MemRead_o, MemWrite_o, MemtoReg_o, ALUSrc_o, Branch_o;
    logic [4:0]  rs1_o, rs2_o, rd_o;
    logic        ill_obs;
`ifdef ILLEGAL_TRAP_EN
    logic        illegal_o;
    assign ill_obs = illegal_o;
`else
    assign ill_obs = 1'b0;
`endif

    id_ctrl_stage dut (
        .clk_i(clk_i), .rst_i(rst_i), .if_valid_i(if_valid_i), .if_instr_i(if_instr_i),
        .if_ready_o(if_ready_o), .flush_i(flush_i), .ex_valid_o(ex_valid_o), .ALUOp_o(ALUOp_o),
        .funct_o(funct_o), .RegWrite_o(RegWrite_o), .MemRead_o(MemRead_o), .MemWrite_o(MemWrite_o),
        .MemtoReg_o(MemtoReg_o), .ALUSrc_o(ALUSrc_o), .Branch_o(Branch_o), .rs1_o(rs1_o),
        .rs2_o(rs2_o), .rd_o(rd_o),
`ifdef ILLEGAL_TRAP_EN
        .illegal_o(illegal_o),
`endif
        .hazard_o(hazard_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #400000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    typedef struct packed {
        logic       v;
        logic [1:0] aluop;
        logic [3:0] funct;
        logic       rw, mr, mw, m2r, src, br;
        logic       ill;
        logic [4:0] rs1, rs2, rd;
    } exo_t;

    int checks = 0;
    int errors = 0;

    // Reference pipeline state
    logic        m_ifv;
    logic [31:0] m_ifi;
    exo_t        m_ex;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    function automatic exo_t ref_decode(input logic [31:0] ins);
        exo_t e;
        e = '0;
        e.v = 1'b1;
        e.rs1 = ins[19:15];
        e.rs2 = ins[24:20];
        e.rd  = ins[11:7];
        case (ins[6:0])
            7'b0110011: begin e.aluop = 2'b10; e.funct = {ins[30], ins[14:12]}; e.rw = 1; end
            7'b0010011: begin
                e.aluop = 2'b11; e.rw = 1; e.src = 1;
                e.funct = (ins[14:12] == 3'b101 && ins[30]) ? 4'b1101 : {1'b0, ins[14:12]};
            end
            7'b0000011: begin e.rw = 1; e.src = 1; e.mr = 1; e.m2r = 1; end
            7'b0100011: begin e.src = 1; e.mw = 1; end
            7'b1100011: begin e.aluop = 2'b01; e.br = 1; end
            default: begin
                e = '0;
`ifdef ILLEGAL_TRAP_EN
                e.v = 1'b1;
                e.ill = 1'b1;
`endif
            end
        endcase
        return e;
    endfunction

    function automatic logic reads_reg(input logic [31:0] ins, input logic [4:0] r);
        logic uses1, uses2;
        uses1 = (ins[6:0] inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011});
        uses2 = (ins[6:0] inside {7'b0110011, 7'b0100011, 7'b1100011});
        return (uses1 && ins[19:15] == r) || (uses2 && ins[24:20] == r);
    endfunction

    function automatic logic ref_hazard();
        return m_ex.v && m_ex.mr && m_ex.rd != 5'd0 && m_ifv && reads_reg(m_ifi, m_ex.rd);
    endfunction

    function automatic exo_t observed();
        exo_t o;
        o = {ex_valid_o, ALUOp_o, funct_o, RegWrite_o, MemRead_o, MemWrite_o, MemtoReg_o,
             ALUSrc_o, Branch_o, ill_obs, rs1_o, rs2_o, rd_o};
        return o;
    endfunction

    task automatic do_reset(input int n);
        rst_i = 1'b1; if_valid_i = 1'b0; flush_i = 1'b0;
        repeat (n) @(posedge clk_i);
        #1;
        m_ifv = 1'b0; m_ifi = NOP; m_ex = '0;
        chk("reset_idex", 32'(observed()), 32'h0);
        chk("reset_ready", 32'(if_ready_o), 32'h1);
        chk("reset_hazard", 32'(hazard_o), 32'h0);
        rst_i = 1'b0;
    endtask

    task automatic step(input logic v, input logic [31:0] ins, input logic fl);
        logic hz;
        if_valid_i = v; if_instr_i = ins; flush_i = fl;
        #4;
        hz = ref_hazard() && !fl;
        chk("hazard", 32'(hazard_o), 32'(hz));
        chk("ready", 32'(if_ready_o), 32'(!hz));
        @(posedge clk_i);
        if (fl) begin
            m_ex = '0; m_ifv = 1'b0; m_ifi = NOP;
        end else if (hz) begin
            m_ex = '0;
        end else begin
            m_ex = m_ifv ? ref_decode(m_ifi) : '0;
            m_ifv = v;
            if (v) m_ifi = ins;
        end
        #1;
        chk("idex", 32'(observed()), 32'(m_ex));
    endtask

    function automatic logic [31:0] rand_insn();
        logic [31:0] ins;
        logic [6:0]  ops[8];
        ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                7'b0000011, 7'b1111111, 7'b0110111};
        ins = $urandom();
        ins[6:0]   = ops[$urandom_range(0, 7)];
        ins[11:7]  = 5'($urandom_range(0, 3));
        ins[19:15] = 5'($urandom_range(0, 3));
        ins[24:20] = 5'($urandom_range(0, 3));
        return ins;
    endfunction

    initial begin
        do_reset(2);

        // add x3,x1,x2
        step(1, 32'h002081B3, 0);
        step(0, 32'h0, 0);
        chk("add_aluop", 32'(ALUOp_o), 32'h2);
        chk("add_funct", 32'(funct_o), 32'h0);
        chk("add_rw", 32'(RegWrite_o), 32'h1);
        chk("add_rd", 32'(rd_o), 32'h3);
        chk("add_valid", 32'(ex_valid_o), 32'h1);

        // sub x5,x6,x7 then beq
        step(1, 32'h407302B3, 0);
        step(1, 32'h00208463, 0);
        chk("sub_funct", 32'(funct_o), 32'h8);
        chk("sub_aluop", 32'(ALUOp_o), 32'h2);
        step(0, 32'h0, 0);
        chk("beq_aluop", 32'(ALUOp_o), 32'h1);
        chk("beq_branch", 32'(Branch_o), 32'h1);

        // lw x1 then dependent add: one stall cycle, bubble, then add
        step(1, 32'h00012083, 0);
        step(1, 32'h002081B3, 0);
        #1;
        chk("lu_hazard", 32'(hazard_o), 32'h1);
        chk("lu_ready", 32'(if_ready_o), 32'h0);
        step(0, 32'h0, 0);
        chk("lu_bubble", 32'(ex_valid_o), 32'h0);
        chk("lu_hazard_over", 32'(hazard_o), 32'h0);
        step(0, 32'h0, 0);
        chk("lu_add_rd", 32'(rd_o), 32'h3);
        chk("lu_add_valid", 32'(ex_valid_o), 32'h1);

        // lw x0 then add reading x0: no stall
        step(1, 32'h00012003, 0);
        step(1, 32'h002001B3, 0);
        #1;
        chk("lw_x0_hazard", 32'(hazard_o), 32'h0);
        step(0, 32'h0, 0);
        step(0, 32'h0, 0);

        // flush during a stall
        step(1, 32'h00012083, 0);
        step(1, 32'h002081B3, 0);
        step(1, 32'h407302B3, 1);
        chk("fl_valid", 32'(ex_valid_o), 32'h0);
        chk("fl_ready", 32'(if_ready_o), 32'h1);
        chk("fl_hazard", 32'(hazard_o), 32'h0);
        step(0, 32'h0, 0);
        chk("fl_ifid_empty", 32'(ex_valid_o), 32'h0);

        // reset mid-stall: held add is lost
        step(1, 32'h00012083, 0);
        step(1, 32'h002081B3, 0);
        do_reset(1);
        step(0, 32'h0, 0);
        chk("rst_stall_lost", 32'(ex_valid_o), 32'h0);

        // unknown opcode
        step(1, 32'hFFFFFFFF, 0);
        step(0, 32'h0, 0);
`ifdef ILLEGAL_TRAP_EN
        chk("ill_pulse", 32'(ill_obs), 32'h1);
        chk("ill_valid", 32'(ex_valid_o), 32'h1);
        chk("ill_ctrl", 32'({RegWrite_o, MemRead_o, MemWrite_o, MemtoReg_o, ALUSrc_o, Branch_o}), 32'h0);
        step(0, 32'h0, 0);
        chk("ill_end", 32'(ill_obs), 32'h0);
`else
        chk("ill_bubble", 32'(ex_valid_o), 32'h0);
`endif

        // random traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset(1);
            end else begin
                step(($urandom_range(0, 9) < 8), rand_insn(), ($urandom_range(0, 19) == 0));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
